// File: rtl/dht11_env_monitor.sv
// dht11_env_monitor: plausibility screen, moving average, hysteretic comfort flags and staleness watchdog for DHT11 readings
module dht11_env_monitor #(
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 25_000_000,
    parameter int T_COLD   = 18,
    parameter int T_HOT    = 30,
    parameter int H_DRY    = 30,
    parameter int H_HUMID  = 70,
    parameter int HYST     = 2,
    parameter int T_MAX    = 60,
    parameter int H_MAX    = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] humidity,
    input  logic [15:0] temperature,
    input  logic        valid,
    output logic [7:0]  temp_avg,
    output logic [7:0]  hum_avg,
    output logic        avg_strobe,
    output logic        avg_ready,
    output logic        cold,
    output logic        hot,
    output logic        dry,
    output logic        humid,
    output logic        stale,
    output logic        reject_pulse,
    output logic [7:0]  reject_cnt
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = 8 + AVG_LOG2;
    localparam int CW    = $clog2(TIMEOUT + 1);
    localparam logic [AVG_LOG2:0] FULL = (AVG_LOG2 + 1)'(DEPTH);
    localparam logic [CW-1:0] TO = CW'(TIMEOUT);
    localparam logic [7:0] TMX   = 8'(T_MAX);
    localparam logic [7:0] HMX   = 8'(H_MAX);
    localparam logic [7:0] C_SET = 8'(T_COLD);
    localparam logic [7:0] C_CLR = 8'(T_COLD + HYST);
    localparam logic [7:0] H_SET = 8'(T_HOT);
    localparam logic [7:0] H_CLR = 8'(T_HOT - HYST);
    localparam logic [7:0] D_SET = 8'(H_DRY);
    localparam logic [7:0] D_CLR = 8'(H_DRY + HYST);
    localparam logic [7:0] U_SET = 8'(H_HUMID);
    localparam logic [7:0] U_CLR = 8'(H_HUMID - HYST);

    typedef enum logic {FILL, RUN} state_e;

    state_e              state;
    logic                s1_acc_q, s1_rej_q, s2_acc_q;
    logic [7:0]          s1_t_q, s1_h_q;
    logic [7:0]          tbuf_q [DEPTH];
    logic [7:0]          hbuf_q [DEPTH];
    logic [SW-1:0]       t_sum_q, t_sum_d, h_sum_q, h_sum_d;
    logic [AVG_LOG2-1:0] wptr_q, wptr_d;
    logic [AVG_LOG2:0]   fill_q, fill_d;
    logic [CW-1:0]       tmr_q, tmr_d;
    logic [7:0]          t_new, h_new, reject_cnt_d;
    logic                cold_d, hot_d, dry_d, humid_d, flag_upd, acc;
    logic                unused_dec;

    assign unused_dec = ^{humidity[7:0], temperature[7:0]};
    assign acc        = temperature[15:8] <= TMX && humidity[15:8] <= HMX;
    assign state      = fill_q == FULL ? RUN : FILL;
    assign t_new      = 8'(t_sum_q >> AVG_LOG2);
    assign h_new      = 8'(h_sum_q >> AVG_LOG2);
    assign stale      = tmr_q == TO;
    assign flag_upd   = s2_acc_q && state == RUN;

    // next-state for window sums, pointers, counters and hysteretic flags
    always_comb begin
        t_sum_d      = s1_acc_q ? t_sum_q + SW'(s1_t_q) - SW'(tbuf_q[wptr_q]) : t_sum_q;
        h_sum_d      = s1_acc_q ? h_sum_q + SW'(s1_h_q) - SW'(hbuf_q[wptr_q]) : h_sum_q;
        wptr_d       = s1_acc_q ? wptr_q + 1'b1 : wptr_q;
        fill_d       = s1_acc_q && state == FILL ? fill_q + 1'b1 : fill_q;
        tmr_d        = valid ? '0 : stale ? tmr_q : tmr_q + 1'b1;
        reject_cnt_d = s1_rej_q && reject_cnt != 8'hFF ? reject_cnt + 8'd1 : reject_cnt;
        cold_d       = !flag_upd ? cold  : t_new <= C_SET ? 1'b1 : t_new >= C_CLR ? 1'b0 : cold;
        hot_d        = !flag_upd ? hot   : t_new >= H_SET ? 1'b1 : t_new <= H_CLR ? 1'b0 : hot;
        dry_d        = !flag_upd ? dry   : h_new <= D_SET ? 1'b1 : h_new >= D_CLR ? 1'b0 : dry;
        humid_d      = !flag_upd ? humid : h_new >= U_SET ? 1'b1 : h_new <= U_CLR ? 1'b0 : humid;
    end

    // three-stage pipeline: capture/screen, window update, average/flag publish
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_acc_q     <= 1'b0;
            s1_rej_q     <= 1'b0;
            s2_acc_q     <= 1'b0;
            s1_t_q       <= '0;
            s1_h_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tbuf_q[i] <= '0;
                hbuf_q[i] <= '0;
            end
            t_sum_q      <= '0;
            h_sum_q      <= '0;
            wptr_q       <= '0;
            fill_q       <= '0;
            tmr_q        <= '0;
            temp_avg     <= '0;
            hum_avg      <= '0;
            avg_strobe   <= 1'b0;
            avg_ready    <= 1'b0;
            cold         <= 1'b0;
            hot          <= 1'b0;
            dry          <= 1'b0;
            humid        <= 1'b0;
            reject_pulse <= 1'b0;
            reject_cnt   <= '0;
        end else begin
            s1_acc_q     <= valid && acc;
            s1_rej_q     <= valid && !acc;
            s1_t_q       <= temperature[15:8];
            s1_h_q       <= humidity[15:8];
            s2_acc_q     <= s1_acc_q;
            if (s1_acc_q) begin
                tbuf_q[wptr_q] <= s1_t_q;
                hbuf_q[wptr_q] <= s1_h_q;
            end
            t_sum_q      <= t_sum_d;
            h_sum_q      <= h_sum_d;
            wptr_q       <= wptr_d;
            fill_q       <= fill_d;
            tmr_q        <= tmr_d;
            reject_pulse <= s1_rej_q;
            reject_cnt   <= reject_cnt_d;
            avg_strobe   <= s2_acc_q;
            if (s2_acc_q) begin
                temp_avg  <= t_new;
                hum_avg   <= h_new;
                avg_ready <= state == RUN;
            end
            cold         <= cold_d;
            hot          <= hot_d;
            dry          <= dry_d;
            humid        <= humid_d;
        end
    end
endmodule

// File: tb/tb_dht11_env_monitor.sv
// tb_dht11_env_monitor: directed vectors with a strobe/reject scoreboard for dht11_env_monitor
module tb_dht11_env_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] humidity = '0;
    logic [15:0] temperature = '0;
    logic        valid = 1'b0;
    logic [7:0]  temp_avg, hum_avg, reject_cnt;
    logic        avg_strobe, avg_ready, cold, hot, dry, humid, stale, reject_pulse;

    typedef struct packed {
        logic [7:0] t;
        logic [7:0] h;
        logic       r;
        logic [3:0] f;
    } res_t;

    typedef struct {
        int   due;
        res_t exp;
    } ev_t;

    ev_t        sbq[$];
    int         rq_due[$];
    logic [7:0] rq_cnt[$];
    ev_t        ev;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    dht11_env_monitor #(.TIMEOUT(1000)) dut (
        .clk(clk), .rst(rst), .humidity(humidity), .temperature(temperature), .valid(valid),
        .temp_avg(temp_avg), .hum_avg(hum_avg), .avg_strobe(avg_strobe), .avg_ready(avg_ready),
        .cold(cold), .hot(hot), .dry(dry), .humid(humid), .stale(stale),
        .reject_pulse(reject_pulse), .reject_cnt(reject_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // monitor: pop and compare whenever the DUT presents a strobe or a reject pulse
    always @(negedge clk) begin
        if (avg_strobe) begin
            if (sbq.size() == 0) chk("strobe_unexpected", 32'(avg_strobe), 32'd0);
            else begin
                ev = sbq.pop_front();
                chk("strobe_cycle", ev.due, cyc);
                chk("strobe_outputs", 32'({temp_avg, hum_avg, avg_ready, cold, hot, dry, humid}), 32'(ev.exp));
            end
        end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
            chk("strobe_missing", 32'(avg_strobe), 32'd1);
            void'(sbq.pop_front());
        end
        if (reject_pulse) begin
            if (rq_due.size() == 0) chk("reject_unexpected", 32'(reject_pulse), 32'd0);
            else begin
                chk("reject_cycle", cyc, rq_due.pop_front());
                chk("reject_cnt", 32'(reject_cnt), 32'(rq_cnt.pop_front()));
            end
        end else if (rq_due.size() > 0 && rq_due[0] < cyc) begin
            chk("reject_missing", 32'(reject_pulse), 32'd1);
            void'(rq_due.pop_front());
            void'(rq_cnt.pop_front());
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] t, input logic [7:0] h);
        temperature = {t, 8'h05};
        humidity    = {h, 8'h09};
        valid       = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic good(input logic [7:0] t, input logic [7:0] h, input logic [7:0] et,
                        input logic [7:0] eh, input logic er, input logic [3:0] ef);
        ev_t e;
        e.due = cyc + 3;
        e.exp = {et, eh, er, ef};
        sbq.push_back(e);
        drive(t, h);
    endtask

    task automatic bad(input logic [7:0] t, input logic [7:0] h, input logic [7:0] ecnt);
        rq_due.push_back(cyc + 2);
        rq_cnt.push_back(ecnt);
        drive(t, h);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sbq.delete();
        rq_due.delete();
        rq_cnt.delete();
        idle(3);
        chk("reset_outputs", 32'({temp_avg, hum_avg, avg_strobe, avg_ready, cold, hot, dry, humid,
                                  stale, reject_pulse, reject_cnt}), 32'd0);
        rst = 1'b1;
    endtask

    task automatic fill_24_50();
        good(24, 50, 6, 12, 0, 4'b0000);
        idle(3);
        good(24, 50, 12, 25, 0, 4'b0000);
        good(24, 50, 18, 37, 0, 4'b0000);
        idle(2);
        good(24, 50, 24, 50, 1, 4'b0000);
        idle(4);
    endtask

    initial begin
        #1;
        do_reset();
        fill_24_50();
        // cold sets at 18, holds through 19, clears at 20
        good(16, 50, 22, 50, 1, 4'b0000);
        good(16, 50, 20, 50, 1, 4'b0000);
        good(16, 50, 18, 50, 1, 4'b1000);
        good(16, 50, 16, 50, 1, 4'b1000);
        good(19, 50, 16, 50, 1, 4'b1000);
        good(19, 50, 17, 50, 1, 4'b1000);
        good(19, 50, 18, 50, 1, 4'b1000);
        good(19, 50, 19, 50, 1, 4'b1000);
        good(24, 50, 20, 50, 1, 4'b0000);
        // hot, humid, dry hysteresis plus T_MAX/H_MAX accepted
        good(40, 50, 25, 50, 1, 4'b0000);
        good(40, 50, 30, 50, 1, 4'b0100);
        good(20, 50, 31, 50, 1, 4'b0100);
        good(20, 50, 30, 50, 1, 4'b0100);
        good(20, 50, 25, 50, 1, 4'b0000);
        good(20, 90, 20, 60, 1, 4'b0000);
        good(20, 90, 20, 70, 1, 4'b0001);
        good(20, 10, 20, 60, 1, 4'b0000);
        good(20, 10, 20, 50, 1, 4'b0000);
        good(20, 10, 20, 30, 1, 4'b0010);
        good(60, 100, 30, 32, 1, 4'b0100);
        idle(4);
        // rejects saturate the counter and leave the averages alone
        bad(61, 40, 1);
        bad(20, 101, 2);
        for (int i = 3; i <= 300; i++) bad(61, 40, i > 255 ? 8'd255 : 8'(i));
        idle(4);
        chk("avg_after_rejects", 32'({temp_avg, hum_avg, cold, hot, dry, humid}), 32'({8'd30, 8'd32, 4'b0100}));
        // stale timer
        idle(991);
        chk("stale_before_timeout", 32'(stale), 32'd0);
        idle(10);
        chk("stale_at_timeout", 32'(stale), 32'd1);
        idle(50);
        chk("stale_holds", 32'(stale), 32'd1);
        bad(61, 40, 255);
        chk("stale_cleared_by_reject", 32'(stale), 32'd0);
        idle(4);
        // reset between valid and strobe discards the sample
        good(40, 40, 0, 0, 0, 4'b0000);
        do_reset();
        idle(5);
        fill_24_50();
        // back-to-back into an empty window, then wrap check
        do_reset();
        good(10, 20, 2, 5, 0, 4'b0000);
        good(20, 40, 7, 15, 0, 4'b0000);
        good(30, 60, 15, 30, 0, 4'b0000);
        good(40, 80, 25, 50, 1, 4'b0000);
        good(50, 60, 35, 60, 1, 4'b0100);
        idle(10);
        chk("strobe_queue_drained", sbq.size(), 32'd0);
        chk("reject_queue_drained", rq_due.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end
endmodule
